disp_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for the 8-digit seven-segment display. It holds a 32-bit hex value and steps a 3-bit digit index at a fixed refresh rate. For each index it presents the matching nibble on dig/data, so the downstream digit decoder drives one anode and its segments at a time. It applies tear-free frame-boundary updates, per-digit blanking and optional leading-zero suppression.

---
 rtl/disp_scan_ctrl.sv | 101 ++++++++++
 tb/tb_disp_scan_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexed scan controller for an 8-digit seven-segment display.
// Holds a double-buffered 32-bit hex value and blank mask. Steps a digit index at a fixed
// refresh rate and presents one registered digit (index, nibble, blank) at a time.
module disp_scan_ctrl #(
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned CNT_W    = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] value,
  input  logic [7:0]  blank_mask,
  input  logic        lz_en,
  output logic [2:0]  dig,
  output logic [3:0]  data,
  output logic        blank,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] LP_TICK_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [2:0]       LP_IDX_MAX  = 3'd7;

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [31:0]      r_act_val;
  logic [7:0]       r_act_mask;
  logic [31:0]      r_pend_val;
  logic [7:0]       r_pend_mask;

  logic             w_tick;
  logic             w_wrap;
  logic [31:0]      w_upper;
  logic [3:0]       w_nib;
  logic             w_lz;
  logic             w_blank;

  // Slot tick, frame wrap, and the nibble/blank for the current index from the active buffer
  always_comb begin
    w_tick  = (r_cnt == LP_TICK_MAX);
    w_wrap  = w_tick && (r_idx == LP_IDX_MAX);
    w_upper = r_act_val >> {r_idx, 2'b00};
    w_nib   = w_upper[3:0];
    // Digit 0 is never suppressed so an all-zero value still shows a single "0"
    w_lz    = lz_en && (r_idx != 3'd0) && (w_upper == 32'd0);
    w_blank = r_act_mask[r_idx] | w_lz;
  end

  // Prescaler and digit index; the index advances once per slot and wraps 7 -> 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= 3'd0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Double buffer: loads land in pending; pending becomes active only on the frame wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_val  <= 32'd0;
      r_pend_mask <= 8'd0;
      r_act_val   <= 32'd0;
      r_act_mask  <= 8'hFF;
      busy        <= 1'b0;
    end else begin
      // The wrap consumes the previously pending value before a same-edge load replaces it
      if (w_wrap && busy) begin
        r_act_val  <= r_pend_val;
        r_act_mask <= r_pend_mask;
      end
      if (load) begin
        r_pend_val  <= value;
        r_pend_mask <= blank_mask;
        busy        <= 1'b1;
      end else if (w_wrap) begin
        busy        <= 1'b0;
      end
    end
  end

  // Registered display outputs, one cycle behind the index change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dig        <= 3'd0;
      data       <= 4'd0;
      blank      <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      dig        <= r_idx;
      data       <= w_nib;
      blank      <= w_blank;
      frame_done <= w_wrap;
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a frame/slot-level model derived from the edge count.
module tb_disp_scan_ctrl;

  localparam int unsigned TD    = 4;
  localparam int unsigned CW    = 3;
  localparam int unsigned FRAME = 8 * TD;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [31:0] value = 32'd0;
  logic [7:0]  blank_mask = 8'd0;
  logic        lz_en = 1'b0;
  logic [2:0]  dig;
  logic [3:0]  data;
  logic        blank;
  logic        busy;
  logic        frame_done;

  disp_scan_ctrl #(.TICK_DIV(TD), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .blank_mask(blank_mask),
    .lz_en(lz_en), .dig(dig), .data(data), .blank(blank), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: n = clock edges since reset release; slot index and frame position follow from n
  int          n;
  logic [31:0] m_act_val, m_pend_val;
  logic [7:0]  m_act_mask, m_pend_mask;
  bit          m_pend;
  logic        cur_lz;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at n=%0d: got %0h expected %0h", nm, n, act, exp);
    end
  endtask

  task automatic model_reset();
    n           = 0;
    m_act_val   = 32'd0;
    m_act_mask  = 8'hFF;
    m_pend_val  = 32'd0;
    m_pend_mask = 8'd0;
    m_pend      = 1'b0;
  endtask

  // Assert reset mid-cycle, check outputs before any clock edge, release after one edge
  task automatic do_reset();
    load  = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_dig",   32'(dig), 32'd0);
    chk("rst_data",  32'(data), 32'd0);
    chk("rst_blank", 32'(blank), 32'd1);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_fd",    32'(frame_done), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // One clock: apply inputs, predict outputs from the model, then compare after the edge
  task automatic step(input logic ld, input logic [31:0] v, input logic [7:0] m, input logic lz);
    int         idx;
    logic [3:0] e_data;
    logic       e_blank;
    logic       e_fd;
    logic       e_busy;
    bit         allz;
    load       = ld;
    value      = v;
    blank_mask = m;
    lz_en      = lz;
    idx     = (n / TD) % 8;
    e_data  = 4'((m_act_val >> (4 * idx)) & 32'hF);
    allz    = 1'b1;
    for (int j = idx; j < 8; j++)
      if (((m_act_val >> (4 * j)) & 32'hF) != 32'd0) allz = 1'b0;
    e_blank = m_act_mask[idx] | (lz && (idx >= 1) && allz);
    e_fd    = ((n + 1) % FRAME) == 0;
    if (e_fd) begin
      if (m_pend) begin
        m_act_val  = m_pend_val;
        m_act_mask = m_pend_mask;
      end
      m_pend = 1'b0;
    end
    if (ld) begin
      m_pend_val  = v;
      m_pend_mask = m;
      m_pend      = 1'b1;
    end
    e_busy = m_pend;
    @(posedge clk);
    #1;
    n++;
    chk("dig",   32'(dig), 32'(idx));
    chk("data",  32'(data), 32'(e_data));
    chk("blank", 32'(blank), 32'(e_blank));
    chk("busy",  32'(busy), 32'(e_busy));
    chk("fd",    32'(frame_done), 32'(e_fd));
    load = 1'b0;
  endtask

  task automatic run_to(input int t);
    while (n < t) step(1'b0, 32'd0, 8'd0, cur_lz);
  endtask

  // Hand-computed expectations that pin the model itself
  task automatic lit(input string nm, input int e_dig, input int e_data, input int e_blank);
    chk({nm, "_dig"},   32'(dig), 32'(e_dig));
    chk({nm, "_data"},  32'(data), 32'(e_data));
    chk({nm, "_blank"}, 32'(blank), 32'(e_blank));
  endtask

  function automatic logic [31:0] rval();
    logic [31:0] v;
    int          len;
    int          nib;
    v   = 32'd0;
    len = $urandom_range(0, 8);
    for (int i = 0; i < len; i++) begin
      nib = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15);
      v   = v | (32'(nib) << (4 * i));
    end
    return v;
  endfunction

  initial begin
    cur_lz = 1'b0;
    model_reset();
    #2;
    do_reset();

    // Idle after reset: dark display, frame pulse every 32 clocks
    run_to(32);
    chk("lit_fd32", 32'(frame_done), 32'd1);
    run_to(33);
    chk("lit_fd33", 32'(frame_done), 32'd0);
    chk("lit_dark", 32'(blank), 32'd1);
    run_to(40);

    // Mid-frame load: busy until wrap, then nibbles F..8 on digits 0..7
    step(1'b1, 32'h89ABCDEF, 8'h00, cur_lz);
    chk("lit_busy_load", 32'(busy), 32'd1);
    run_to(64);
    chk("lit_busy_wrap", 32'(busy), 32'd0);
    run_to(65);
    lit("lit_d0", 0, 4'hF, 0);
    run_to(69);
    lit("lit_d1", 1, 4'hE, 0);
    run_to(93);
    lit("lit_d7", 7, 4'h8, 0);

    // Leading-zero suppression
    cur_lz = 1'b1;
    step(1'b1, 32'h00000A50, 8'h00, cur_lz);
    run_to(97);
    lit("lit_lz0", 0, 0, 0);
    run_to(101);
    lit("lit_lz1", 1, 5, 0);
    run_to(105);
    lit("lit_lz2", 2, 4'hA, 0);
    run_to(109);
    lit("lit_lz3", 3, 0, 1);
    step(1'b1, 32'h00000000, 8'h00, cur_lz);
    run_to(129);
    lit("lit_zero0", 0, 0, 0);
    run_to(133);
    lit("lit_zero1", 1, 0, 1);

    // Two loads in one frame: last one wins
    cur_lz = 1'b0;
    run_to(140);
    step(1'b1, 32'h11111111, 8'h00, cur_lz);
    step(1'b1, 32'h22222222, 8'h00, cur_lz);
    run_to(161);
    lit("lit_two0", 0, 2, 0);
    run_to(177);
    lit("lit_two4", 4, 2, 0);

    // Load on the wrap edge: prior pending applies now, the new value one frame later
    run_to(185);
    step(1'b1, 32'h33333333, 8'h00, cur_lz);
    run_to(191);
    step(1'b1, 32'h44444444, 8'h00, cur_lz);
    chk("lit_busy_wrapload", 32'(busy), 32'd1);
    run_to(193);
    lit("lit_wl_old", 0, 3, 0);
    run_to(223);
    chk("lit_busy_hold", 32'(busy), 32'd1);
    run_to(225);
    lit("lit_wl_new", 0, 4, 0);
    chk("lit_busy_clr", 32'(busy), 32'd0);

    // Reset during digit 5 with a load pending
    step(1'b1, 32'h55555555, 8'h00, cur_lz);
    run_to(246);
    chk("lit_pre_rst_dig", 32'(dig), 32'd5);
    do_reset();
    run_to(80);
    lit("lit_post_rst", 3'(((n - 1) / TD) % 8), 0, 1);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 15) == 0) cur_lz = ~cur_lz;
        if ($urandom_range(0, 15) == 0)
          step(1'b1, rval(), ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00, cur_lz);
        else
          step(1'b0, 32'($urandom), 8'($urandom), cur_lz);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
